// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and the hard-wired zero-register index for reg_file.
package reg_file_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int ZERO_REG  = 0;
endpackage

// File: rtl/reg_file_cell.sv
// reg_cell: one WIDTH-bit storage register with write enable and async active-low clear.
module reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] val_q, val_d;
  always_comb val_d = en ? d : val_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  assign q = val_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: register file with two read ports and a per-register pending scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             WE,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             busy_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy_b
);
  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             wr_ok, rsv_ok;
  assign wr_ok  = WE && waddr != ZERO;
  assign rsv_ok = rsv && rsv_addr != ZERO;
  assign regs[ZERO_REG] = '0;
  genvar i;
  generate
    for (i = 1; i < DEPTH; i++) begin : g_cell
      reg_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_ok && waddr == AW'(i)),
        .d     (wdata),
        .q     (regs[i])
      );
    end
  endgenerate
  // Set after clear so a same-cycle reserve beats the write's clear.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[waddr]    = 1'b0;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    pend_d[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
`ifdef REG_FILE_BYPASS_EN
  logic byp_a, byp_b;
  always_comb begin
    byp_a   = rst_n && wr_ok && waddr == raddr_a;
    byp_b   = rst_n && wr_ok && waddr == raddr_b;
    rdata_a = byp_a ? wdata : regs[raddr_a];
    rdata_b = byp_b ? wdata : regs[raddr_b];
    busy_a  = byp_a ? rsv && rsv_addr == raddr_a : pend_q[raddr_a];
    busy_b  = byp_b ? rsv && rsv_addr == raddr_b : pend_q[raddr_b];
  end
`else
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    busy_a  = pend_q[raddr_a];
    busy_b  = pend_q[raddr_b];
  end
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array-based model.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n, WE, rsv;
  logic [2:0]  waddr, rsv_addr, raddr_a, raddr_b;
  logic [15:0] wdata, rdata_a, rdata_b;
  logic        busy_a, busy_b;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mem  [8];
  logic        pend [8];

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .WE(WE), .waddr(waddr), .wdata(wdata),
    .rsv(rsv), .rsv_addr(rsv_addr), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .busy_a(busy_a), .raddr_b(raddr_b), .rdata_b(rdata_b), .busy_b(busy_b)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) begin
      mem[k]  = 16'h0;
      pend[k] = 1'b0;
    end
  endfunction

  function automatic logic [15:0] exp_data(input logic [2:0] a);
    if (a == 3'd0 || !rst_n) return 16'h0;
`ifdef REG_FILE_BYPASS_EN
    if (WE && waddr == a) return wdata;
`endif
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (a == 3'd0 || !rst_n) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (WE && waddr == a) return rsv && rsv_addr == a;
`endif
    return pend[a];
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      if (WE && waddr != 3'd0) begin
        mem[waddr]  = wdata;
        pend[waddr] = 1'b0;
      end
      if (rsv && rsv_addr != 3'd0) pend[rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    WE = 1'b0; rsv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; WE = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; rsv = 1'b1; rsv_addr = 3'd3;
    raddr_a = 3'd3; raddr_b = 3'd3;
    model_clear();
    @(negedge clk); cycle(); cycle();
    #1;
    n_cmp++; if (rdata_a !== 16'h0) begin n_err++; $display("FAIL reset_rdata_a got %h exp 0000", rdata_a); end
    n_cmp++; if (rdata_b !== 16'h0) begin n_err++; $display("FAIL reset_rdata_b got %h exp 0000", rdata_b); end
    n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b%b exp 00", busy_a, busy_b); end
    idle();
    rst_n = 1'b1;
    cycle(); #1;
    n_cmp++; if (rdata_a !== 16'h0) begin n_err++; $display("FAIL reset_r3_after got %h exp 0000", rdata_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_r3_busy got %b exp 0", busy_a); end
  endtask

  task automatic test_write_read();
    WE = 1'b1; waddr = 3'd5; wdata = 16'h1234;
    cycle(); idle();
    raddr_a = 3'd5; raddr_b = 3'd5; #1;
    n_cmp++; if (rdata_a !== 16'h1234) begin n_err++; $display("FAIL wr_rdata_a got %h exp 1234", rdata_a); end
    n_cmp++; if (rdata_b !== 16'h1234) begin n_err++; $display("FAIL wr_rdata_b got %h exp 1234", rdata_b); end
    WE = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
    cycle(); idle();
    raddr_a = 3'd0; raddr_b = 3'd5; #1;
    n_cmp++; if (rdata_a !== 16'h0) begin n_err++; $display("FAIL wr_r0 got %h exp 0000", rdata_a); end
    n_cmp++; if (rdata_b !== 16'h1234) begin n_err++; $display("FAIL wr_r0_side_effect got %h exp 1234", rdata_b); end
  endtask

  task automatic test_scoreboard();
    rsv = 1'b1; rsv_addr = 3'd2;
    cycle(); idle();
    raddr_a = 3'd2; #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL sb_busy_set got %b exp 1", busy_a); end
    rsv = 1'b1; rsv_addr = 3'd2;
    cycle(); idle(); #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL sb_double_rsv got %b exp 1", busy_a); end
    WE = 1'b1; waddr = 3'd2; wdata = 16'h00AA;
    cycle(); idle(); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL sb_busy_clear got %b exp 0", busy_a); end
    n_cmp++; if (rdata_a !== 16'h00AA) begin n_err++; $display("FAIL sb_rdata got %h exp 00aa", rdata_a); end
    rsv = 1'b1; rsv_addr = 3'd0;
    cycle(); idle();
    raddr_b = 3'd0; #1;
    n_cmp++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL sb_r0_busy got %b exp 0", busy_b); end
    WE = 1'b1; waddr = 3'd3; wdata = 16'h0033;
    cycle(); idle();
    raddr_b = 3'd3; #1;
    n_cmp++; if (busy_b !== 1'b0 || rdata_b !== 16'h0033) begin n_err++; $display("FAIL sb_plain_write got %b/%h exp 0/0033", busy_b, rdata_b); end
  endtask

  task automatic test_collision();
    rsv = 1'b1; rsv_addr = 3'd4; WE = 1'b1; waddr = 3'd4; wdata = 16'h5555;
    raddr_a = 3'd4; raddr_b = 3'd4; #1;
    n_cmp++; if (busy_a !== exp_busy(3'd4)) begin n_err++; $display("FAIL col_busy_pre got %b exp %b", busy_a, exp_busy(3'd4)); end
    cycle(); idle(); #1;
    n_cmp++; if (rdata_a !== 16'h5555) begin n_err++; $display("FAIL col_rdata got %h exp 5555", rdata_a); end
    n_cmp++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin n_err++; $display("FAIL col_busy got %b%b exp 11", busy_a, busy_b); end
  endtask

  task automatic test_bypass();
    logic [15:0] e_d;
    logic        e_b;
    rsv = 1'b1; rsv_addr = 3'd6;
    cycle(); idle();
    WE = 1'b1; waddr = 3'd6; wdata = 16'hC0DE; raddr_b = 3'd6; #1;
`ifdef REG_FILE_BYPASS_EN
    e_d = 16'hC0DE; e_b = 1'b0;
`else
    e_d = mem[6]; e_b = 1'b1;
`endif
    n_cmp++; if (rdata_b !== e_d) begin n_err++; $display("FAIL byp_rdata got %h exp %h", rdata_b, e_d); end
    n_cmp++; if (busy_b !== e_b) begin n_err++; $display("FAIL byp_busy got %b exp %b", busy_b, e_b); end
    cycle(); idle(); #1;
    n_cmp++; if (rdata_b !== 16'hC0DE || busy_b !== 1'b0) begin n_err++; $display("FAIL byp_after got %h/%b exp c0de/0", rdata_b, busy_b); end
  endtask

  task automatic test_mid_reset();
    rsv = 1'b1; rsv_addr = 3'd1;
    cycle();
    rsv_addr = 3'd7;
    cycle(); idle();
    raddr_a = 3'd1; raddr_b = 3'd7; #1;
    n_cmp++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin n_err++; $display("FAIL mr_pre got %b%b exp 11", busy_a, busy_b); end
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_err++; $display("FAIL mr_busy got %b%b exp 00", busy_a, busy_b); end
    WE = 1'b1; waddr = 3'd5; wdata = 16'hDEAD; rsv = 1'b1; rsv_addr = 3'd5;
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a); raddr_b = 3'(7 - a); #1;
      n_cmp++; if (rdata_a !== 16'h0 || rdata_b !== 16'h0) begin n_err++; $display("FAIL mr_reg%0d got %h/%h exp 0000", a, rdata_a, rdata_b); end
    end
    idle();
    @(negedge clk); rst_n = 1'b1;
    cycle(); #1;
    n_cmp++; if (busy_a !== 1'b0 || rdata_a !== 16'h0) begin n_err++; $display("FAIL mr_after got %b/%h exp 0/0000", busy_a, rdata_a); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      WE = $urandom_range(0, 1) == 1; waddr = 3'($urandom); wdata = 16'($urandom);
      rsv = $urandom_range(0, 2) == 0; rsv_addr = 3'($urandom);
      raddr_a = 3'($urandom);
      raddr_b = $urandom_range(0, 3) == 0 ? raddr_a : 3'($urandom);
      #1;
      n_cmp++; if (rdata_a !== exp_data(raddr_a) || busy_a !== exp_busy(raddr_a)) begin n_err++; $display("FAIL rnd_a[%0d] addr %0d got %h/%b exp %h/%b", n, raddr_a, rdata_a, busy_a, exp_data(raddr_a), exp_busy(raddr_a)); end
      n_cmp++; if (rdata_b !== exp_data(raddr_b) || busy_b !== exp_busy(raddr_b)) begin n_err++; $display("FAIL rnd_b[%0d] addr %0d got %h/%b exp %h/%b", n, raddr_b, rdata_b, busy_b, exp_data(raddr_b), exp_busy(raddr_b)); end
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
